// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the arbiter, the shared ALU and the response consumer.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface alu_arbiter_if #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_zero, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_zero, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU: one operation in flight,
// fairness from a priority pointer that flips to the other requester after every grant.
//
// state | meaning
// IDLE  | waiting for a request; grant computed combinationally
// EXEC  | operands registered and driving the ALU for one cycle
// RESP  | result held on the response port until rsp_ready
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             take0;
    logic             take1;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [OPW-1:0]   opnd_op;
    logic             opnd_id;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_id_q;

    always_comb begin
        state_nxt = state;
        take0     = 1'b0;
        take1     = 1'b0;
        case (state)
            IDLE: begin
                // readys are also held low while rst is asserted
                take0 = !rst && bus.req0_valid && (!bus.req1_valid || !prio);
                take1 = !rst && bus.req1_valid && (!bus.req0_valid ||  prio);
                if (take0 || take1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            prio         <= 1'b0;
            opnd_a       <= '0;
            opnd_b       <= '0;
            opnd_op      <= '0;
            opnd_id      <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take0 || take1) begin
                opnd_a  <= take1 ? bus.req1_a  : bus.req0_a;
                opnd_b  <= take1 ? bus.req1_b  : bus.req0_b;
                opnd_op <= take1 ? bus.req1_op : bus.req0_op;
                opnd_id <= take1;
                prio    <= ~take1;
            end
            if (state == EXEC) begin
                rsp_result_q <= bus.alu_result;
                rsp_zero_q   <= bus.alu_zero;
                rsp_id_q     <= opnd_id;
            end
        end
    end

    assign bus.req0_ready = take0;
    assign bus.req1_ready = take1;
    assign bus.alu_a      = opnd_a;
    assign bus.alu_b      = opnd_b;
    assign bus.alu_op     = opnd_op;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of grant order, latency and results.
module tb_alu_arbiter;
    localparam int WIDTH = 64;
    localparam int OPW   = 4;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_CBZ = 4'b0111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic prio_m = 1'b0;

    alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared datapath: undefined opcodes produce a XOR so pass-through is observable
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_op)
            OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            OP_ORR:  bus.alu_result = bus.alu_a | bus.alu_b;
            OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
            OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
            OP_CBZ:  bus.alu_result = bus.alu_a;
            default: bus.alu_result = bus.alu_a ^ bus.alu_b;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    function automatic logic [63:0] model_result(input logic [63:0] a, input logic [63:0] b,
                                                 input logic [3:0] op);
        if (op == OP_AND) return a & b;
        if (op == OP_ORR) return a | b;
        if (op == OP_ADD) return a + b;
        if (op == OP_SUB) return a - b;
        if (op == OP_CBZ) return a;
        return a ^ b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic issue(input logic v0, input logic v1,
                         input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] op0,
                         input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] op1,
                         input int bp);
        logic        g_any;
        logic        g;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] er;
        logic [3:0]  eop;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        bus.rsp_ready  = (bp == 0);
        g_any = v0 | v1;
        g     = (v0 && v1) ? prio_m : v1;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        chk("idle_ready0", bus.req0_ready, g_any && !g);
        chk("idle_ready1", bus.req1_ready, g_any && g);
        if (!g_any) begin
            @(posedge clk); #1;
            return;
        end
        ea  = g ? a1 : a0;
        eb  = g ? b1 : b0;
        eop = g ? op1 : op0;
        er  = model_result(ea, eb, eop);
        @(posedge clk); #1;
        // scramble the accepted requester's ports: the ALU must run from registered operands
        if (g) begin
            bus.req1_valid = 0; bus.req1_a = {$urandom, $urandom}; bus.req1_b = {$urandom, $urandom};
        end else begin
            bus.req0_valid = 0; bus.req0_a = {$urandom, $urandom}; bus.req0_b = {$urandom, $urandom};
        end
        prio_m = ~g;
        @(negedge clk);
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        chk("exec_busy", bus.busy, 1);
        chk("exec_ready0", bus.req0_ready, 0);
        chk("exec_ready1", bus.req1_ready, 0);
        chk("exec_alu_a", bus.alu_a, ea);
        chk("exec_alu_b", bus.alu_b, eb);
        chk("exec_alu_op", bus.alu_op, eop);
        @(negedge clk);
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_id", bus.rsp_id, g);
        chk("rsp_result", bus.rsp_result, er);
        chk("rsp_zero", bus.rsp_zero, er == 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_id", bus.rsp_id, g);
            chk("bp_rsp_result", bus.rsp_result, er);
            chk("bp_rsp_zero", bus.rsp_zero, er == 0);
            chk("bp_busy", bus.busy, 1);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
        end
        bus.rsp_ready = 1;
        @(posedge clk); #1;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        bus.rsp_ready  = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        rst    = 0;
        prio_m = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] ops [7];
        logic [63:0] ra;
        logic [63:0] rb;
        int pat;
        ops[0] = OP_AND; ops[1] = OP_ORR; ops[2] = OP_ADD; ops[3] = OP_SUB;
        ops[4] = OP_CBZ; ops[5] = 4'hF;   ops[6] = 4'h3;

        bus.req0_valid = 1; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
        bus.req1_valid = 1; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
        bus.rsp_ready  = 0;
        #2;
        chk("por_ready0", bus.req0_ready, 0);
        chk("por_ready1", bus.req1_ready, 0);
        chk("por_busy", bus.busy, 0);
        chk("por_rsp_valid", bus.rsp_valid, 0);
        chk("por_rsp_result", bus.rsp_result, 0);
        chk("por_rsp_id", bus.rsp_id, 0);
        chk("por_rsp_zero", bus.rsp_zero, 0);
        chk("por_alu_a", bus.alu_a, 0);
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;

        // ADD 5+3 from req0
        issue(1, 0, 5, 3, OP_ADD, 0, 0, OP_AND, 0);
        // simultaneous requests right after reset: req0 first, then req1
        do_reset();
        issue(1, 1, 5, 5, OP_SUB, 64'hF0F0, 64'h0F0F, OP_ORR, 0);
        issue(0, 1, 0, 0, OP_AND, 64'hF0F0, 64'h0F0F, OP_ORR, 0);
        // backpressure with req1 waiting
        issue(1, 1, 7, 9, OP_AND, 1, 2, OP_ADD, 4);
        issue(0, 1, 0, 0, OP_AND, 1, 2, OP_ADD, 0);
        // lone req1: ADD 0,0 then CBZ-pass 10,0
        issue(0, 1, 0, 0, OP_AND, 0, 0, OP_ADD, 0);
        issue(0, 1, 0, 0, OP_AND, 10, 0, OP_CBZ, 0);
        // undefined opcode passes through
        issue(1, 0, 10, 20, 4'hF, 0, 0, OP_AND, 1);
        // idle cycle with no request leaves priority untouched
        issue(0, 0, 0, 0, OP_AND, 0, 0, OP_AND, 0);

        // reset while EXEC for req0 SUB 3,5
        bus.req0_valid = 1; bus.req0_a = 3; bus.req0_b = 5; bus.req0_op = OP_SUB;
        @(negedge clk);
        chk("mid_ready0", bus.req0_ready, 1);
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_ready0", bus.req0_ready, 0);
        chk("mid_rst_alu_a", bus.alu_a, 0);
        chk("mid_rst_alu_op", bus.alu_op, 0);
        chk("mid_rst_rsp_result", bus.rsp_result, 0);
        bus.req0_valid = 0;
        @(negedge clk);
        rst    = 0;
        prio_m = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", bus.rsp_valid, 0);
            chk("post_rst_busy", bus.busy, 0);
        end
        @(posedge clk); #1;
        issue(0, 1, 0, 0, OP_AND, 1, 1, OP_ADD, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            pat = $urandom_range(0, 3);
            ra  = {$urandom, $urandom};
            rb  = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            issue(pat[0], pat[1],
                  ra, rb, ops[$urandom_range(0, 6)],
                  rb, {$urandom, $urandom}, ops[$urandom_range(0, 6)],
                  $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
